// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: round-robin grant of one unit literal per cycle from the
// process engines, with duplicate filtering, conflict detection and a broadcast push.
module uc_arbiter #(
    parameter int NUM_ENG   = 4,
    parameter int UC_LENGTH = 1024,
    parameter int LIT_W     = $clog2(UC_LENGTH),
    parameter int NUM_VAR   = UC_LENGTH / 2,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [NUM_ENG-1:0]            eng2uca_valid,
    input  logic [NUM_ENG-1:0][LIT_W-1:0] eng2uca_lit,
    output logic [NUM_ENG-1:0]            uca2eng_ready,
    input  logic [NUM_ENG-1:0]            ucq_full,
    output logic [LIT_W-1:0]              uca2ucq,
    output logic                          uca2ucq_push,
    output logic                          conflict,
    output logic [LIT_W-1:0]              conflict_lit,
    output logic [CNT_W-1:0]              push_cnt,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam int               PTR_W     = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int               VAR_W     = LIT_W - 1;
    localparam logic [PTR_W:0]   NUM_ENG_W = (PTR_W + 1)'(NUM_ENG);
    localparam logic [PTR_W-1:0] LAST_ENG  = PTR_W'(NUM_ENG - 1);

    typedef enum logic [1:0] {
        CLS_NEW  = 2'd0,
        CLS_DUP  = 2'd1,
        CLS_CONF = 2'd2
    } cls_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_VAR-1:0] assigned;
    logic [NUM_VAR-1:0] value_tbl;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W:0]     cand;
    logic [LIT_W-1:0]   win_lit;
    logic [VAR_W-1:0]   win_var;
    logic               win_pol;
    cls_t               cls;
    logic               grant;
    logic               push;

    // Winner search: first valid engine at or after rr_ptr, wrapping modulo NUM_ENG.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (cand >= NUM_ENG_W) begin
                cand = cand - NUM_ENG_W;
            end
            if (!found && eng2uca_valid[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = cand[PTR_W-1:0];
            end
        end
    end

    assign win_lit = eng2uca_lit[win];
    assign win_var = win_lit[LIT_W-1:1];
    assign win_pol = win_lit[0];

    always_comb begin
        cls = CLS_NEW;
        if (assigned[win_var]) begin
            cls = (value_tbl[win_var] == win_pol) ? CLS_DUP : CLS_CONF;
        end
    end

    // A full queue only blocks NEW literals; DUP and CONF are consumed without a push.
    // The rst term keeps grant and push low combinationally while reset is held.
    assign grant = rst && found && !conflict && !clear
                   && ((cls != CLS_NEW) || !(|ucq_full));
    assign push  = grant && (cls == CLS_NEW);

    always_comb begin
        uca2eng_ready = '0;
        if (grant) begin
            uca2eng_ready[win] = 1'b1;
        end
    end

    assign uca2ucq_push = push;
    assign uca2ucq      = push ? win_lit : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            assigned     <= '0;
            conflict     <= 1'b0;
            conflict_lit <= '0;
            push_cnt     <= '0;
            drop_cnt     <= '0;
        end else if (clear) begin
            assigned     <= '0;
            conflict     <= 1'b0;
            conflict_lit <= '0;
            push_cnt     <= '0;
            drop_cnt     <= '0;
        end else if (grant) begin
            rr_ptr <= (win == LAST_ENG) ? '0 : win + 1'b1;
            case (cls)
                CLS_NEW: begin
                    assigned[win_var] <= 1'b1;
                    push_cnt          <= sat_inc(push_cnt);
                end
                CLS_DUP: begin
                    drop_cnt <= sat_inc(drop_cnt);
                end
                default: begin
                    conflict     <= 1'b1;
                    conflict_lit <= win_lit;
                end
            endcase
        end
    end

    // Polarity is only meaningful where assigned is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            value_tbl[win_var] <= win_pol;
        end
    end

endmodule

// File: tb/tb_uc_arbiter.sv
// Directed table-driven bench for uc_arbiter: each row applies one cycle of requests,
// checks the combinational grant/push, then the registered state after the edge.
module tb_uc_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [3:0]       eng2uca_valid;
    logic [3:0][9:0]  eng2uca_lit;
    logic [3:0]       uca2eng_ready;
    logic [3:0]       ucq_full;
    logic [9:0]       uca2ucq;
    logic             uca2ucq_push;
    logic             conflict;
    logic [9:0]       conflict_lit;
    logic [15:0]      push_cnt;
    logic [15:0]      drop_cnt;

    int errors = 0;
    int checks = 0;

    uc_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .eng2uca_valid(eng2uca_valid),
        .eng2uca_lit  (eng2uca_lit),
        .uca2eng_ready(uca2eng_ready),
        .ucq_full     (ucq_full),
        .uca2ucq      (uca2ucq),
        .uca2ucq_push (uca2ucq_push),
        .conflict     (conflict),
        .conflict_lit (conflict_lit),
        .push_cnt     (push_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      valid;
        logic [3:0][9:0] lit;
        logic [3:0]      full;
        logic            clr;
        logic [3:0]      e_ready;
        logic            e_push;
        logic [9:0]      e_ucq;
        logic            e_conf;
        logic [9:0]      e_clit;
        logic [15:0]     e_pcnt;
        logic [15:0]     e_dcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] valid, input logic [9:0] l0, input logic [9:0] l1,
                       input logic [9:0] l2, input logic [9:0] l3, input logic [3:0] full,
                       input logic clr, input logic [3:0] e_ready, input logic e_push,
                       input logic [9:0] e_ucq, input logic e_conf, input logic [9:0] e_clit,
                       input logic [15:0] e_pcnt, input logic [15:0] e_dcnt);
        vec_t v;
        v.valid   = valid;
        v.lit     = {l3, l2, l1, l0};
        v.full    = full;
        v.clr     = clr;
        v.e_ready = e_ready;
        v.e_push  = e_push;
        v.e_ucq   = e_ucq;
        v.e_conf  = e_conf;
        v.e_clit  = e_clit;
        v.e_pcnt  = e_pcnt;
        v.e_dcnt  = e_dcnt;
        vecs.push_back(v);
    endtask

    initial begin
        // valid  lit0    lit1    lit2    lit3    full  clr  ready  push ucq     conf clit   pcnt dcnt
        // Round-robin over four engines from rr_ptr = 0.
        add(4'b1111, 10'h010, 10'h020, 10'h030, 10'h040, 4'b0000, 1'b0, 4'b0001, 1'b1, 10'h010, 1'b0, 10'h000, 16'd1, 16'd0);
        add(4'b1110, 10'h010, 10'h020, 10'h030, 10'h040, 4'b0000, 1'b0, 4'b0010, 1'b1, 10'h020, 1'b0, 10'h000, 16'd2, 16'd0);
        add(4'b1100, 10'h010, 10'h020, 10'h030, 10'h040, 4'b0000, 1'b0, 4'b0100, 1'b1, 10'h030, 1'b0, 10'h000, 16'd3, 16'd0);
        add(4'b1000, 10'h010, 10'h020, 10'h030, 10'h040, 4'b0000, 1'b0, 4'b1000, 1'b1, 10'h040, 1'b0, 10'h000, 16'd4, 16'd0);
        // Single engine, rr_ptr back at 0.
        add(4'b0001, 10'h004, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b0, 4'b0001, 1'b1, 10'h004, 1'b0, 10'h000, 16'd5, 16'd0);
        // Same variable from engines 1 and 2: NEW then DUP.
        add(4'b0110, 10'h000, 10'h00A, 10'h00A, 10'h000, 4'b0000, 1'b0, 4'b0010, 1'b1, 10'h00A, 1'b0, 10'h000, 16'd6, 16'd0);
        add(4'b0100, 10'h000, 10'h00A, 10'h00A, 10'h000, 4'b0000, 1'b0, 4'b0100, 1'b0, 10'h000, 1'b0, 10'h000, 16'd6, 16'd1);
        // DUP still dropped while a queue is full (rr_ptr = 3 wraps to engine 0).
        add(4'b0001, 10'h004, 10'h000, 10'h000, 10'h000, 4'b0100, 1'b0, 4'b0001, 1'b0, 10'h000, 1'b0, 10'h000, 16'd6, 16'd2);
        // NEW stalls while full, no skip to engine 2.
        add(4'b0010, 10'h000, 10'h060, 10'h000, 10'h000, 4'b0100, 1'b0, 4'b0000, 1'b0, 10'h000, 1'b0, 10'h000, 16'd6, 16'd2);
        add(4'b0110, 10'h000, 10'h060, 10'h070, 10'h000, 4'b0100, 1'b0, 4'b0000, 1'b0, 10'h000, 1'b0, 10'h000, 16'd6, 16'd2);
        add(4'b0110, 10'h000, 10'h060, 10'h070, 10'h000, 4'b0000, 1'b0, 4'b0010, 1'b1, 10'h060, 1'b0, 10'h000, 16'd7, 16'd2);
        add(4'b0100, 10'h000, 10'h060, 10'h070, 10'h000, 4'b0000, 1'b0, 4'b0100, 1'b1, 10'h070, 1'b0, 10'h000, 16'd8, 16'd2);
        // Conflict: 00B against assigned 00A.
        add(4'b1000, 10'h000, 10'h000, 10'h000, 10'h00B, 4'b0000, 1'b0, 4'b1000, 1'b0, 10'h000, 1'b1, 10'h00B, 16'd8, 16'd2);
        add(4'b0001, 10'h050, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000, 1'b1, 10'h00B, 16'd8, 16'd2);
        // Clear pulse: no grant that cycle, state wiped, rr_ptr kept at 0.
        add(4'b0001, 10'h050, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b1, 4'b0000, 1'b0, 10'h000, 1'b0, 10'h000, 16'd0, 16'd0);
        add(4'b0001, 10'h050, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b0, 4'b0001, 1'b1, 10'h050, 1'b0, 10'h000, 16'd1, 16'd0);
        // Table was wiped: 004 is NEW again.
        add(4'b0010, 10'h000, 10'h004, 10'h000, 10'h000, 4'b0000, 1'b0, 4'b0010, 1'b1, 10'h004, 1'b0, 10'h000, 16'd2, 16'd0);

        // Reset with a request pending.
        rst           = 1'b0;
        clear         = 1'b0;
        ucq_full      = 4'b0000;
        eng2uca_valid = 4'b0001;
        eng2uca_lit   = {10'h000, 10'h000, 10'h000, 10'h004};
        #1;
        chk("rst_ready", {28'd0, uca2eng_ready}, 32'd0);
        chk("rst_push", {31'd0, uca2ucq_push}, 32'd0);
        chk("rst_ucq", {22'd0, uca2ucq}, 32'd0);
        chk("rst_conflict", {31'd0, conflict}, 32'd0);
        chk("rst_conflict_lit", {22'd0, conflict_lit}, 32'd0);
        chk("rst_push_cnt", {16'd0, push_cnt}, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // First test-plan case: engine 0 offers 004 straight out of reset.
        #3;
        chk("first_ready", {28'd0, uca2eng_ready}, 32'h1);
        chk("first_push", {31'd0, uca2ucq_push}, 32'd1);
        chk("first_ucq", {22'd0, uca2ucq}, 32'h004);
        @(posedge clk);
        #1;
        chk("first_push_cnt", {16'd0, push_cnt}, 32'd1);

        // Restart from a clean state so the table rows begin at rr_ptr = 0.
        eng2uca_valid = 4'b0000;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            eng2uca_valid = vecs[i].valid;
            eng2uca_lit   = vecs[i].lit;
            ucq_full      = vecs[i].full;
            clear         = vecs[i].clr;
            #3;
            chk($sformatf("v%0d_ready", i), {28'd0, uca2eng_ready}, {28'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_push", i), {31'd0, uca2ucq_push}, {31'd0, vecs[i].e_push});
            chk($sformatf("v%0d_ucq", i), {22'd0, uca2ucq}, {22'd0, vecs[i].e_ucq});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_conflict", i), {31'd0, conflict}, {31'd0, vecs[i].e_conf});
            chk($sformatf("v%0d_conflict_lit", i), {22'd0, conflict_lit}, {22'd0, vecs[i].e_clit});
            chk($sformatf("v%0d_push_cnt", i), {16'd0, push_cnt}, {16'd0, vecs[i].e_pcnt});
            chk($sformatf("v%0d_drop_cnt", i), {16'd0, drop_cnt}, {16'd0, vecs[i].e_dcnt});
        end

        // Mid-operation reset: 050 is assigned, so it is a DUP before reset and NEW after.
        clear         = 1'b0;
        ucq_full      = 4'b0000;
        eng2uca_valid = 4'b0001;
        eng2uca_lit   = {10'h000, 10'h000, 10'h000, 10'h050};
        #2;
        chk("pre_rst_ready", {28'd0, uca2eng_ready}, 32'h1);
        chk("pre_rst_push", {31'd0, uca2ucq_push}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", {28'd0, uca2eng_ready}, 32'd0);
        chk("mid_rst_push", {31'd0, uca2ucq_push}, 32'd0);
        chk("mid_rst_ucq", {22'd0, uca2ucq}, 32'd0);
        chk("mid_rst_push_cnt", {16'd0, push_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        chk("post_rst_ready", {28'd0, uca2eng_ready}, 32'h1);
        chk("post_rst_push", {31'd0, uca2ucq_push}, 32'd1);
        chk("post_rst_ucq", {22'd0, uca2ucq}, 32'h050);
        @(posedge clk);
        #1;
        chk("post_rst_push_cnt", {16'd0, push_cnt}, 32'd1);
        chk("post_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
